lcv_mul_acc_sched: RTL and testbench

- Round-robin scheduler that shares one pipelined 16x16+33 signed multiply-accumulate unit between NUM_REQ requesters.
- Each requester issues at most one operation at a time and gets its result back in a private, backpressured response slot.
- Optional accumulate mode chains a requester's previous result in as the addend.
- Sits between client engines and a single MAC instance, with the MAC register depth given by MAC_LATENCY.

---
 rtl/lcv_mul_acc_sched.sv | 122 ++++++++++++
 tb/tb_lcv_mul_acc_sched.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcv_mul_acc_sched.sv
// Round-robin scheduler sharing one pipelined signed MAC (a*b+c+d+e) among NUM_REQ requesters,
// with one outstanding operation and one backpressured response slot per requester.
module lcv_mul_acc_sched #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned MAC_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*16-1:0]  req_a,
  input  logic [NUM_REQ*16-1:0]  req_b,
  input  logic [NUM_REQ*33-1:0]  req_c,
  input  logic [NUM_REQ-1:0]     req_acc,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [NUM_REQ*33-1:0]  rsp_data,
  output logic [15:0]            mac_a,
  output logic [15:0]            mac_b,
  output logic [32:0]            mac_c,
  output logic [32:0]            mac_d,
  output logic [32:0]            mac_e,
  input  logic [32:0]            mac_outp
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]                busy_q;
  logic [NUM_REQ-1:0]                rsp_valid_q;
  logic [32:0]                       rsp_data_q [NUM_REQ];
  logic [IW-1:0]                     rr_ptr_q;
  logic [MAC_LATENCY-1:0]            tag_vld_q;
  logic [MAC_LATENCY-1:0][IW-1:0]    tag_idx_q;

  logic [15:0] a_arr [NUM_REQ];
  logic [15:0] b_arr [NUM_REQ];
  logic [32:0] c_arr [NUM_REQ];

  logic [NUM_REQ-1:0] elig;
  logic               grant_vld;
  logic [IW-1:0]      grant_idx;
  logic [IW-1:0]      scan;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign a_arr[g]              = req_a[16*g +: 16];
    assign b_arr[g]              = req_b[16*g +: 16];
    assign c_arr[g]              = req_c[33*g +: 33];
    assign rsp_data[33*g +: 33]  = rsp_data_q[g];
  end

  assign rsp_valid = rsp_valid_q;
  assign mac_d     = '0;
  assign mac_e     = '0;

  // Nothing is granted while reset is held, so no tag can enter during reset.
  assign elig = req_valid & ~busy_q & {NUM_REQ{~rst}};

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan      = rr_ptr_q;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!grant_vld && elig[scan]) begin
        grant_vld = 1'b1;
        grant_idx = scan;
      end
      scan = (scan == IW'(NUM_REQ - 1)) ? '0 : scan + 1'b1;
    end
  end

  always_comb begin
    req_ready = '0;
    mac_a     = '0;
    mac_b     = '0;
    mac_c     = '0;
    if (grant_vld) begin
      req_ready[grant_idx] = 1'b1;
      mac_a                = a_arr[grant_idx];
      mac_b                = b_arr[grant_idx];
      mac_c                = req_acc[grant_idx] ? rsp_data_q[grant_idx] : c_arr[grant_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= '0;
      rsp_valid_q <= '0;
      rr_ptr_q    <= '0;
      tag_vld_q   <= '0;
      tag_idx_q   <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        rsp_data_q[i] <= '0;
      end
    end else begin
      tag_vld_q[0] <= grant_vld;
      tag_idx_q[0] <= grant_idx;
      for (int unsigned i = 1; i < MAC_LATENCY; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_idx_q[i] <= tag_idx_q[i-1];
      end

      if (grant_vld) begin
        busy_q[grant_idx] <= 1'b1;
        rr_ptr_q          <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end

      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (rsp_valid_q[i] && rsp_ready[i]) begin
          rsp_valid_q[i] <= 1'b0;
          busy_q[i]      <= 1'b0;
        end
      end

      // A requester is busy until its response is taken, so exit and handshake never collide.
      if (tag_vld_q[MAC_LATENCY-1]) begin
        rsp_valid_q[tag_idx_q[MAC_LATENCY-1]] <= 1'b1;
        rsp_data_q[tag_idx_q[MAC_LATENCY-1]]  <= mac_outp;
      end
    end
  end

endmodule

// File: tb/tb_lcv_mul_acc_sched.sv
// Bench for lcv_mul_acc_sched: external MAC model, per-cycle transaction-level scoreboard and
// directed scenarios with hand-computed expectations.
module tb_lcv_mul_acc_sched;

  localparam int N = 4;
  localparam int L = 1;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*16-1:0] req_a;
  logic [N*16-1:0] req_b;
  logic [N*33-1:0] req_c;
  logic [N-1:0]    req_acc;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [N*33-1:0] rsp_data;
  logic [15:0]     mac_a;
  logic [15:0]     mac_b;
  logic [32:0]     mac_c;
  logic [32:0]     mac_d;
  logic [32:0]     mac_e;
  logic [32:0]     mac_outp;

  int n_vec = 0;
  int n_err = 0;

  lcv_mul_acc_sched #(.NUM_REQ(N), .MAC_LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_acc(req_acc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_d(mac_d), .mac_e(mac_e),
    .mac_outp(mac_outp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External MAC: L register stages, not reset.
  logic [32:0] mac_pipe [L];
  always @(posedge clk) begin
    mac_pipe[0] <= 33'(longint'($signed(mac_a)) * longint'($signed(mac_b))
                       + longint'($signed(mac_c)) + longint'($signed(mac_d))
                       + longint'($signed(mac_e)));
    for (int i = 1; i < L; i++) mac_pipe[i] <= mac_pipe[i-1];
  end
  assign mac_outp = mac_pipe[L-1];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: one outstanding op per requester, result lands L+1 cycles after issue.
  logic        m_busy [N];
  logic        m_vld  [N];
  logic [32:0] m_data [N];
  logic [32:0] m_res  [N];
  int          m_cd   [N];
  int          m_rr;

  initial begin
    int          g;
    logic [15:0] ea, eb;
    logic [32:0] ec;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rdy_in_reset", 64'(req_ready), 64'd0);
        for (int i = 0; i < N; i++) begin
          m_busy[i] = 1'b0; m_vld[i] = 1'b0; m_data[i] = '0; m_cd[i] = 0;
        end
        m_rr = 0;
      end else begin
        g = -1;
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_rr + k) % N;
          if (g < 0 && req_valid[j] && !m_busy[j]) g = j;
        end
        ea = '0; eb = '0; ec = '0;
        if (g >= 0) begin
          ea = req_a[16*g +: 16];
          eb = req_b[16*g +: 16];
          ec = req_acc[g] ? m_data[g] : req_c[33*g +: 33];
        end
        check("req_ready", 64'(req_ready), (g >= 0) ? (64'd1 << g) : 64'd0);
        check("mac_a", 64'(mac_a), 64'(ea));
        check("mac_b", 64'(mac_b), 64'(eb));
        check("mac_c", 64'(mac_c), 64'(ec));
        check("mac_de", 64'({mac_d, mac_e}), 64'd0);
        for (int i = 0; i < N; i++) begin
          check("rsp_valid", 64'(rsp_valid[i]), 64'(m_vld[i]));
          check("rsp_data", 64'(rsp_data[33*i +: 33]), 64'(m_data[i]));
        end
        for (int i = 0; i < N; i++) begin
          if (m_cd[i] == 1) check("one_outstanding", 64'(m_vld[i]), 64'd0);
          if (m_vld[i] && rsp_ready[i]) begin
            m_vld[i]  = 1'b0;
            m_busy[i] = 1'b0;
          end
          if (m_cd[i] > 0) begin
            m_cd[i]--;
            if (m_cd[i] == 0) begin
              m_vld[i]  = 1'b1;
              m_data[i] = m_res[i];
            end
          end
        end
        if (g >= 0) begin
          m_busy[g] = 1'b1;
          m_cd[g]   = L;
          m_res[g]  = 33'(longint'($signed(ea)) * longint'($signed(eb)) + longint'($signed(ec)));
          m_rr      = (g + 1) % N;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic [32:0] c, input logic acc);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
    req_c[33*i +: 33] = c;
    req_acc[i]        = acc;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
  endtask

  // Issue one op on requester i, wait for its response, check latency.
  task automatic issue_wait(input int i, input logic [15:0] a, input logic [15:0] b,
                            input logic [32:0] c, input logic acc);
    int n;
    set_req(i, a, b, c, acc);
    req_valid[i] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[i] && n < 20) begin
      cyc(); #1; n++;
    end
    check("grant_timeout", 64'(req_ready[i]), 64'd1);
    cyc();
    req_valid[i] = 1'b0;
    n = 0;
    while (!rsp_valid[i] && n < 20) begin
      cyc(); n++;
    end
    check("rsp_arrive", 64'(rsp_valid[i]), 64'd1);
    check("latency", 64'(n), 64'(L));
  endtask

  logic [N-1:0] grants [8];
  int           others;

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_c = '0; req_acc = '0;
    rsp_ready = '1;
    cyc();
    req_valid = '1;
    #1 check("lit_rdy_reset", 64'(req_ready), 64'd0);
    req_valid = '0;
    do_reset();

    // Single op: 3 * -4 + 5 = -7
    set_req(0, 16'd3, 16'hFFFC, 33'd5, 1'b0);
    req_valid[0] = 1'b1;
    #1 check("lit_grant0", 64'(req_ready), 64'd1);
    cyc();
    req_valid[0] = 1'b0;
    cyc();
    check("lit_rsp_valid0", 64'(rsp_valid[0]), 64'd1);
    check("lit_rsp_data0", 64'(rsp_data[32:0]), 64'h1_FFFF_FFF9);
    repeat (2) cyc();

    // All four requesting: grants 0,1,2,3 then 0 again
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 16'(i + 1), 16'(2 * i + 3), 33'(i * 100), 1'b0);
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      #1 grants[k] = req_ready;
      cyc();
    end
    check("lit_rr0", 64'(grants[0]), 64'h1);
    check("lit_rr1", 64'(grants[1]), 64'h2);
    check("lit_rr2", 64'(grants[2]), 64'h4);
    check("lit_rr3", 64'(grants[3]), 64'h8);
    check("lit_rr4", 64'(grants[4]), 64'h1);
    req_valid = '0;
    repeat (4) cyc();

    // Accumulate chain on requester 2: 16, 22, 28
    do_reset();
    issue_wait(2, 16'd2, 16'd3, 33'd10, 1'b0);
    check("lit_acc1", 64'(rsp_data[66 +: 33]), 64'd16);
    cyc();
    issue_wait(2, 16'd2, 16'd3, 33'd999, 1'b1);
    check("lit_acc2", 64'(rsp_data[66 +: 33]), 64'd22);
    cyc();
    issue_wait(2, 16'd2, 16'd3, 33'd999, 1'b1);
    check("lit_acc3", 64'(rsp_data[66 +: 33]), 64'd28);
    repeat (2) cyc();

    // Backpressure on requester 1 while 0 and 3 keep being served; 5*7+1 = 36
    rsp_ready = 4'b1101;
    set_req(0, 16'd9, 16'd9, 33'd0, 1'b0);
    set_req(1, 16'd5, 16'd7, 33'd1, 1'b0);
    set_req(3, 16'hFFFF, 16'd4, 33'd2, 1'b0);
    req_valid = 4'b1011;
    others = 0;
    for (int k = 0; k < 20 && !rsp_valid[1]; k++) cyc();
    check("bp_arrive", 64'(rsp_valid[1]), 64'd1);
    for (int k = 0; k < 5; k++) begin
      check("bp_valid_hold", 64'(rsp_valid[1]), 64'd1);
      check("bp_data_hold", 64'(rsp_data[33 +: 33]), 64'd36);
      check("bp_no_grant1", 64'(req_ready[1]), 64'd0);
      if ((req_ready & 4'b1001) != 0) others++;
      cyc();
    end
    check("bp_others_served", 64'(others > 0), 64'd1);
    rsp_ready = '1;
    req_valid = '0;
    repeat (4) cyc();

    // Overflow: 2^30 + 2^32 - 1 wraps to -3221225473
    issue_wait(0, 16'h8000, 16'h8000, 33'h0_FFFF_FFFF, 1'b0);
    check("lit_overflow", 64'(rsp_data[32:0]), 64'h1_3FFF_FFFF);
    repeat (2) cyc();

    // Reset while requester 3 is in flight
    set_req(3, 16'd11, 16'd11, 33'd0, 1'b0);
    req_valid = 4'b1000;
    #1 check("lit_grant3", 64'(req_ready), 64'h8);
    cyc();
    req_valid = '0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("lit_dropped", 64'(rsp_valid), 64'd0);
      cyc();
    end
    req_valid = 4'b1001;
    #1 check("lit_post_reset_rr", 64'(req_ready), 64'h1);
    cyc();
    req_valid = '0;
    repeat (4) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
